fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage RISC-V integer pipeline.
- Keeps shadow copies of the destination fields of the instructions in EX, MEM and WB.
- From these it drives the select inputs of the ALU operand-A mux (PC/Reg/DMEM/WB) and operand-B mux (Reg/DMEM/WB).
- Detects load-use hazards, stalls IF/ID, and inserts bubbles into EX on stall or branch flush.

---
 rtl/fwd_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - forwarding mux selects, load-use stall and EX bubble control
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwen,
  input  logic              id_memread,
  input  logic              id_use_pc,
  input  logic              ex_flush,
  output logic              a_sel1,
  output logic [1:0]        a_sel2,
  output logic [1:0]        b_sel2,
  output logic              stall,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  // EX shadow fields
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_regwen_q, ex_regwen_d;
  logic              ex_memread_q, ex_memread_d;
  logic              ex_use_pc_q, ex_use_pc_d;

  // MEM shadow fields
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_regwen_q;
  logic              mem_memread_q;

  // WB shadow fields
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              wb_regwen_q;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic load_use;
  logic rs1_dep, rs2_dep;
  logic mem_fwd_ok, wb_fwd_ok;
  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

  // Load in EX whose rd is read by the instruction in ID
  always_comb begin
    rs1_dep  = id_use_rs1 & (id_rs1 == ex_rd_q);
    rs2_dep  = id_use_rs2 & (id_rs2 == ex_rd_q);
    load_use = id_valid & ex_valid_q & ex_memread_q & ex_regwen_q &
               (ex_rd_q != '0) & (rs1_dep | rs2_dep);
  end

  // Flush overrides the stall since the ID instruction is squashed anyway;
  // gating with rst_n keeps both controls low for the whole reset window.
  assign stall     = rst_n & load_use & ~ex_flush;
  assign ex_bubble = stall | (rst_n & ex_flush);
  assign stall_cnt = cnt_q;

  // Next EX contents: ID fields, or an all-zero NOP when bubbling
  always_comb begin
    ex_valid_d   = id_valid;
    ex_rs1_d     = id_rs1;
    ex_rs2_d     = id_rs2;
    ex_rd_d      = id_rd;
    ex_regwen_d  = id_regwen;
    ex_memread_d = id_memread;
    ex_use_pc_d  = id_use_pc;
    if (ex_bubble) begin
      ex_valid_d   = 1'b0;
      ex_rs1_d     = '0;
      ex_rs2_d     = '0;
      ex_rd_d      = '0;
      ex_regwen_d  = 1'b0;
      ex_memread_d = 1'b0;
      ex_use_pc_d  = 1'b0;
    end
  end

  // Saturating count of load-use stall cycles
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline shadow registers; MEM and WB advance every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_regwen_q   <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_use_pc_q   <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_rd_q      <= '0;
      mem_regwen_q  <= 1'b0;
      mem_memread_q <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_regwen_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_regwen_q   <= ex_regwen_d;
      ex_memread_q  <= ex_memread_d;
      ex_use_pc_q   <= ex_use_pc_d;
      mem_valid_q   <= ex_valid_q;
      mem_rd_q      <= ex_rd_q;
      mem_regwen_q  <= ex_regwen_q;
      mem_memread_q <= ex_memread_q;
      wb_valid_q    <= mem_valid_q;
      wb_rd_q       <= mem_rd_q;
      wb_regwen_q   <= mem_regwen_q;
      cnt_q         <= cnt_d;
    end
  end

  // Producer matches; loads in MEM and x0 never forward
  always_comb begin
    mem_fwd_ok = mem_valid_q & mem_regwen_q & ~mem_memread_q & (mem_rd_q != '0);
    wb_fwd_ok  = wb_valid_q & wb_regwen_q & (wb_rd_q != '0);
    mem_hit_a  = mem_fwd_ok & (mem_rd_q == ex_rs1_q);
    mem_hit_b  = mem_fwd_ok & (mem_rd_q == ex_rs2_q);
    wb_hit_a   = wb_fwd_ok & (wb_rd_q == ex_rs1_q);
    wb_hit_b   = wb_fwd_ok & (wb_rd_q == ex_rs2_q);
  end

  // Operand mux selects for the EX instruction; MEM beats WB, PC beats both
  always_comb begin
    a_sel1 = 1'b0;
    a_sel2 = 2'b00;
    b_sel2 = 2'b00;
    if (ex_valid_q) begin
      if (ex_use_pc_q) begin
        a_sel1 = 1'b1;
      end else if (mem_hit_a) begin
        a_sel2 = 2'b10;
      end else if (wb_hit_a) begin
        a_sel2 = 2'b01;
      end
      if (mem_hit_b) begin
        b_sel2 = 2'b10;
      end else if (wb_hit_b) begin
        b_sel2 = 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwen, id_memread, id_use_pc;
  logic       ex_flush;

  logic        a_sel1, s_a_sel1;
  logic [1:0]  a_sel2, b_sel2, s_a_sel2, s_b_sel2;
  logic        stall, ex_bubble, s_stall, s_ex_bubble;
  logic [15:0] stall_cnt;
  logic [3:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_exp = 0;
  int sat_exp = 0;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwen(id_regwen),
    .id_memread(id_memread), .id_use_pc(id_use_pc), .ex_flush(ex_flush),
    .a_sel1(a_sel1), .a_sel2(a_sel2), .b_sel2(b_sel2), .stall(stall),
    .ex_bubble(ex_bubble), .stall_cnt(stall_cnt)
  );

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwen(id_regwen),
    .id_memread(id_memread), .id_use_pc(id_use_pc), .ex_flush(ex_flush),
    .a_sel1(s_a_sel1), .a_sel2(s_a_sel2), .b_sel2(s_b_sel2), .stall(s_stall),
    .ex_bubble(s_ex_bubble), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic wen, input logic mr, input logic pc, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwen = wen; id_memread = mr; id_use_pc = pc; ex_flush = fl;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sels(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, a_sel1, a_sel2, b_sel2}, {27'd0, exp});
  endtask

  task automatic ctl(input string tag, input logic st, input logic bb);
    chk(tag, {30'd0, stall, ex_bubble}, {30'd0, st, bb});
  endtask

  task automatic cnts(input string tag);
    chk({tag, "_cnt"}, {16'd0, stall_cnt}, cnt_exp);
    chk({tag, "_sat"}, {28'd0, s_stall_cnt}, sat_exp);
  endtask

  task automatic bump();
    cnt_exp++;
    if (sat_exp < 15) sat_exp++;
  endtask

  initial begin
    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)),
          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)));
      @(negedge clk);
      sels("rst_sel", 5'b00000);
      ctl("rst_ctl", 1'b0, 1'b0);
      cnts("rst");
      tick();
    end
    nop();
    rst_n = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    sels("post_rst_sel", 5'b00000);
    ctl("post_rst_ctl", 1'b0, 1'b0);
    cnts("post_rst");
    tick();

    // Back-to-back ALU dependency: add x5,x1,x2 ; sub x6,x5,x7 ; or x12,x5,x13
    drv(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0);
    @(negedge clk); tick();
    drv(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0);
    @(negedge clk);
    sels("alu_prod_ex", 5'b00000);
    ctl("alu_nostall", 1'b0, 1'b0);
    tick();
    drv(1, 5'd5, 5'd13, 1, 1, 5'd12, 1, 0, 0, 0);
    @(negedge clk);
    sels("alu_mem_fwd", 5'b01000);
    tick();
    nop();
    @(negedge clk);
    sels("alu_wb_fwd", 5'b00100);
    tick();
    @(negedge clk); tick();
    @(negedge clk); tick();

    // Load-use: lw x8,0(x2) ; add x9,x8,x8
    drv(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0);
    @(negedge clk);
    ctl("lu_lw_id", 1'b0, 1'b0);
    tick();
    drv(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0);
    @(negedge clk);
    ctl("lu_stall", 1'b1, 1'b1);
    cnts("lu_pre");
    tick();
    bump();
    @(negedge clk);
    ctl("lu_one_cycle", 1'b0, 1'b0);
    cnts("lu_post");
    sels("lu_bubble_ex", 5'b00000);
    tick();
    nop();
    @(negedge clk);
    sels("lu_wb_fwd", 5'b00101);
    tick();
    @(negedge clk); tick();
    @(negedge clk); tick();

    // Double producer of x3, MEM wins; then x0 producer never forwards
    drv(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
    @(negedge clk); tick();
    drv(1, 5'd2, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
    @(negedge clk); tick();
    drv(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0);
    @(negedge clk); tick();
    drv(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0);
    @(negedge clk);
    sels("dbl_mem_wins", 5'b01010);
    tick();
    drv(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0, 0);
    @(negedge clk); tick();
    nop();
    @(negedge clk);
    sels("x0_no_fwd", 5'b00000);
    tick();
    @(negedge clk); tick();
    @(negedge clk); tick();

    // AUIPC in EX with a stale rs1 field matching a MEM producer: PC wins
    drv(1, 5'd1, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0);
    @(negedge clk); tick();
    drv(1, 5'd4, 5'd0, 0, 0, 5'd7, 1, 0, 1, 0);
    @(negedge clk); tick();
    nop();
    @(negedge clk);
    sels("auipc_pc", 5'b10000);
    tick();

    // Flush in the same cycle as a load-use condition
    drv(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0);
    @(negedge clk); tick();
    drv(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 0, 1);
    @(negedge clk);
    ctl("flush_wins", 1'b0, 1'b1);
    tick();
    nop();
    @(negedge clk);
    cnts("flush_nocnt");
    ctl("after_flush", 1'b0, 1'b0);
    sels("flush_bubble_ex", 5'b00000);
    tick();

    // Saturation: 20 load-use stalls
    for (int i = 0; i < 20; i++) begin
      drv(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0);
      @(negedge clk); tick();
      drv(1, 5'd0, 5'd8, 0, 1, 5'd9, 1, 0, 0, 0);
      @(negedge clk);
      ctl("sat_stall", 1'b1, 1'b1);
      tick();
      bump();
      @(negedge clk); tick();
    end
    nop();
    @(negedge clk);
    cnts("sat_end");
    tick();

    // Reset asserted mid-stall drops stall immediately
    drv(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0);
    @(negedge clk); tick();
    drv(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0);
    @(negedge clk);
    ctl("pre_rst_stall", 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    cnt_exp = 0;
    sat_exp = 0;
    ctl("midstall_rst", 1'b0, 1'b0);
    cnts("midstall_rst");
    tick();
    nop();
    rst_n = 1'b1;
    @(negedge clk);
    sels("final_sel", 5'b00000);
    ctl("final_ctl", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
